// File: rtl/dpram_pkg.sv
// Shared constants and FSM encoding for the dual-port RAM stream reader.
package dpram_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dpram_skid_fifo.sv
// Small output buffer absorbing RAM read data while the stream sink stalls.
module dpram_skid_fifo
    import dpram_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATAWIDTH-1:0]  push_data,
    input  logic                  pop,
    output logic [DATAWIDTH-1:0]  pop_data,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATAWIDTH-1:0]  slot_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                slot_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign pop_data = slot_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/dpram_stream_reader.sv
// Streams a burst of words out of a dual-port RAM read port (1-cycle latency)
// onto a valid/ready interface, never holding more than FIFO_DEPTH words in flight.
module dpram_stream_reader
    import dpram_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] start_addr,
    input  logic [ADDRWIDTH:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] mem_address,
    output logic                 mem_wren,
    input  logic [DATAWIDTH-1:0] mem_q,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned OCC_W = FIFO_CNT_W + 1;

    state_e                state_q, state_d;
    logic [ADDRWIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDRWIDTH-1:0]  hold_addr_q, hold_addr_d;
    logic [ADDRWIDTH:0]    remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;

    logic                  pop;
    logic                  issue;
    logic [OCC_W-1:0]      occ_after;
    logic                  fifo_push, fifo_pop;
    logic [DATAWIDTH-1:0]  fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_full, fifo_empty;

    // An empty FIFO lets the returning RAM word bypass straight to the output;
    // it is only written into the FIFO when the sink does not take it at once.
    assign out_valid = !fifo_empty || inflight_q;
    assign out_data  = !fifo_empty ? fifo_head : (inflight_q ? mem_q : '0);
    assign pop       = out_valid && out_ready;
    assign fifo_pop  = pop && !fifo_empty;
    assign fifo_push = inflight_q && !(fifo_empty && pop);

    // Words buffered or in flight once this cycle's pop is taken into account.
    assign occ_after = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = (state_q == ST_READ) && (occ_after < OCC_W'(FIFO_DEPTH));

    assign mem_address = issue ? rd_addr_q : hold_addr_q;
    assign mem_wren    = 1'b0;
    assign busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        hold_addr_d = issue ? rd_addr_q : hold_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_addr_d   = start_addr;
                    remaining_d = length;
                    state_d     = (length == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    rd_addr_d   = rd_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (ADDRWIDTH + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (occ_after == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            hold_addr_q <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            hold_addr_q <= hold_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    dpram_skid_fifo #(
        .DATAWIDTH (DATAWIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mem_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(fifo_push && !fifo_pop && fifo_full));

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Randomized bench for dpram_stream_reader against a burst-level reference model.
module tb_dpram_stream_reader;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;
    logic [7:0] mem_address;
    logic       mem_wren;
    logic [7:0] mem_q;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    dpram_stream_reader #(
        .DATAWIDTH (8),
        .ADDRWIDTH (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Dual-port RAM model: registered read port, 1-cycle latency.
    logic [7:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    end
    always @(posedge clock) mem_q <= ram[mem_address];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state, one burst at a time.
    logic [7:0] exp_q [$];
    bit         m_active = 0;
    int         m_len = 0;
    int         start_cyc = 0;
    bit         first_pending = 0;
    int         issued = 0;
    int         popped = 0;
    logic [7:0] next_addr = 8'h00;
    int         last_pop_cyc = 0;
    bit         prev_valid = 0;
    bit         prev_ready = 0;
    logic [7:0] prev_data = 8'h00;
    int         done_count = 0;

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            m_active      = 0;
            first_pending = 0;
            prev_valid    = 0;
        end else begin
            check("wren", 32'(mem_wren), 32'd0);
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (m_active && issued < m_len) begin
                if (issued == 0) begin
                    if (cyc == start_cyc + 1) begin
                        check("first_addr", 32'(mem_address), 32'(next_addr));
                        issued++;
                        next_addr = next_addr + 8'd1;
                    end
                end else if (mem_address == next_addr) begin
                    issued++;
                    next_addr = next_addr + 8'd1;
                end
            end
            if (out_valid && first_pending) begin
                check("first_latency", 32'(cyc - start_cyc), 32'd2);
                first_pending = 0;
            end
            if (out_valid && exp_q.size() == 0) check("valid_no_word", 32'(out_valid), 32'd0);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("data", 32'(out_data), 32'(exp_q.pop_front()));
                popped++;
                if (exp_q.size() == 0) last_pop_cyc = cyc;
            end
            if (m_active) check("outstanding_le2", 32'(issued - popped <= 2), 32'd1);
            if (m_active && m_len == 0) check("busy_len0", 32'(busy), 32'd0);
            if (start && !m_active) begin
                m_active      = 1;
                m_len         = int'(length);
                start_cyc     = cyc;
                issued        = 0;
                popped        = 0;
                next_addr     = start_addr;
                first_pending = (length != 9'd0);
                for (int i = 0; i < int'(length); i++) begin
                    exp_q.push_back((start_addr + 8'(i)) ^ 8'hA5);
                end
            end else if (done) begin
                if (!m_active) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    check("done_cycle", 32'(cyc),
                          32'((m_len == 0) ? start_cyc + 1 : last_pop_cyc + 1));
                    check("words_left", 32'(exp_q.size()), 32'd0);
                    check("reads_issued", 32'(issued), 32'(m_len));
                    m_active = 0;
                    done_count++;
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_addr"}, 32'(mem_address), 32'd0);
        check({tag, "_wren"}, 32'(mem_wren), 32'd0);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_burst(input logic [7:0] sa, input int len, input int pct, input bit poke);
        int dc;
        int n;
        dc         = done_count;
        start      = 1'b1;
        start_addr = sa;
        length     = 9'(len);
        out_ready  = ($urandom_range(99) < pct);
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (done_count == dc && n < 3000) begin
            out_ready = ($urandom_range(99) < pct);
            if (poke && n == 2) begin
                start      = 1'b1;
                start_addr = 8'h99;
                length     = 9'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            n++;
        end
        start = 1'b0;
        check("burst_completes", 32'(done_count != dc), 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = 8'h00;
        length     = 9'd0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        run_burst(8'h10, 4, 100, 0);
        run_burst(8'hFE, 4, 100, 0);
        run_burst(8'h00, 0, 100, 0);
        run_burst(8'h33, 256, 30, 0);
        run_burst(8'h80, 12, 50, 0);
        run_burst(8'h60, 8, 70, 1);

        // Reset in the middle of the third word of an 8-word burst.
        start      = 1'b1;
        start_addr = 8'h20;
        length     = 9'd8;
        out_ready  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        @(posedge clock); #1;
        reset = 1'b0;
        run_burst(8'h40, 6, 100, 0);

        for (int k = 0; k < 4; k++) begin
            run_burst(8'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(20, 100)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_stream_reader.md
DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

Interface
REQ-001 Parameters SHALL be, one per line:
- DATAWIDTH, default 8, word width.
- ADDRWIDTH, default 8, address width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE.
- start_addr  in  ADDRWIDTH  first word address of the burst.
- length  in  ADDRWIDTH+1  word count, 0 to 2**ADDRWIDTH.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word has been consumed.
- mem_address  out  ADDRWIDTH  dual-port RAM read-port address.
- mem_wren  out  1  dual-port RAM write enable; constant 0.
- mem_q  in  DATAWIDTH  dual-port RAM read data; valid one cycle after the address.
- out_data  out  DATAWIDTH  stream data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  sink accepts out_data when out_valid and out_ready are both high.

Function
REQ-003 States SHALL be IDLE, READ, DRAIN and DONE.
REQ-004 IDLE SHALL go to READ on start with length>0, and to DONE on start with length==0.
REQ-005 READ SHALL go to DRAIN in the cycle the final read is issued.
REQ-006 DRAIN SHALL go to DONE when no read is in flight and the output buffer is empty.
REQ-007 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-008 done SHALL be high only in DONE; busy SHALL be high in READ and DRAIN.
REQ-009 The RAM read latency SHALL be taken as exactly 1 cycle. mem_q is captured in the cycle after mem_address was issued.
REQ-010 Output SHALL be buffered in a 2-entry FIFO. A read SHALL be issued in a cycle only if (fifo_count + inflight - pop) < 2.
- inflight = 1 if a read was issued in the previous cycle, otherwise 0.
- pop = out_valid && out_ready.
REQ-011 With out_ready held high, READ SHALL issue one read per cycle, for throughput of 1 word per cycle.
REQ-012 Latency from accepted start to first out_valid SHALL be 2 cycles: address issued in the cycle after start, data presented the cycle after that.
REQ-013 Addresses SHALL increment by 1 per issued read, modulo 2**ADDRWIDTH. A burst crossing the top address wraps to 0.
REQ-014 Exactly length words SHALL be delivered, in address order, with none dropped or duplicated under any out_ready pattern.
REQ-015 out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-016 start SHALL be ignored while not in IDLE; the current burst continues unaffected.
REQ-017 When no read is issued, mem_address SHALL hold its last value.
REQ-018 mem_wren SHALL be 0 at all times, including during reset.

Reset
REQ-019 Asserting reset SHALL immediately force, in any state including mid-burst:
- state IDLE; busy=0, done=0, out_valid=0;
- FIFO and in-flight flag cleared;
- mem_address=0, out_data=0.
REQ-020 After reset deassertion the block SHALL accept start on the first clock edge; data from an interrupted burst SHALL never appear.

Structure
REQ-021 State encodings and the FIFO depth constant (2) SHALL reside in the shared package dpram_pkg.
REQ-022 The 2-entry FIFO SHALL be a separate sub-module, dpram_skid_fifo, with push/pop/count/full/empty and the same clock/reset.
REQ-023 The block SHALL connect to the existing dual-port RAM read port (address_b/wren_b/q_b) without glue logic.

Verification
REQ-024 The bench SHALL use a dual-port RAM model with 1-cycle latency, preloaded mem[i]=i^8'hA5. It SHALL cover these scenarios:
- start_addr=0x10, length=4, out_ready=1 -> out_data A5^10..A5^13 on consecutive cycles; first out_valid 2 cycles after start; done 1 cycle after last pop.
- start_addr=0xFE, length=4 -> reads from addresses FE, FF, 00, 01 in order.
- length=0 -> no read issued, out_valid never high, done pulses the cycle after start, busy stays 0.
- length=256, out_ready random at 30% -> 256 words in order, no loss or duplicate, out_data stable while stalled, at most 2 reads outstanding.
- reset asserted during the third word of an 8-word burst -> outputs zero asynchronously; a new burst at 0x40 returns only A5^40 onward.
- start pulsed again mid-burst -> ignored; the original burst completes intact.
